uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/rr_priority_pick.sv | 18 +
 rtl/uart_tx_arbiter.sv | 79 +++++++
 tb/tb_uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared arbiter state type and round-robin helper
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, FORWARD, TAG} arb_state_t;
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last);
    logic [3:0] idx;
    rr_next = last;
    for (int i = 16; i >= 1; i--) begin
      idx = last + 4'(i);
      if (req[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotate-priority encoder, first requester strictly after last (up to 16 requesters)
module rr_priority_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         found
);
  // unused upper request bits are zero, so a 16-wide rotation equals an N-wide one
  always_comb begin
    idx = W'(rr_next(16'(req), 4'(last)));
    found = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin mux of AXI-Stream sources onto one UART tx; UART_TX_ARB_TAG_EN adds a source-id tag beat
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int WORD_WIDTH  = 8,
  parameter int MAX_BURST   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SOURCES*WORD_WIDTH-1:0] din_axis_tdata,
  input  logic [NUM_SOURCES-1:0]            din_axis_tvalid,
  input  logic [NUM_SOURCES-1:0]            din_axis_tlast,
  output logic [NUM_SOURCES-1:0]            din_axis_tready,
  output logic [WORD_WIDTH-1:0]             dout_axis_tdata,
  output logic                              dout_axis_tvalid,
  input  logic                              dout_axis_tready,
  output logic [$clog2(NUM_SOURCES)-1:0]    grant_id
);
  localparam int GW = $clog2(NUM_SOURCES);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_t state;
  logic [CW-1:0] beats;
  logic [GW-1:0] pick;
  logic found, fwd, tag, sel_valid, sel_last;
  logic [WORD_WIDTH-1:0] sel_data;
  rr_priority_pick #(.N(NUM_SOURCES), .W(GW)) u_pick (
    .req(din_axis_tvalid),
    .last(grant_id),
    .idx(pick),
    .found(found)
  );
  assign fwd = state == FORWARD;
`ifdef UART_TX_ARB_TAG_EN
  assign tag = state == TAG;
  if (WORD_WIDTH < GW) begin : g_tag_width_check
    $error("WORD_WIDTH too narrow to carry the source tag");
  end
`else
  assign tag = 1'b0;
`endif
  assign sel_data  = din_axis_tdata[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
  assign sel_valid = din_axis_tvalid[grant_id];
  assign sel_last  = din_axis_tlast[grant_id];
  // unregistered pass-through of the granted source; tag beat carries the grant index
  always_comb begin
    dout_axis_tvalid = fwd ? sel_valid : tag;
    dout_axis_tdata = fwd && sel_valid ? sel_data : tag ? WORD_WIDTH'(grant_id) : '0;
    din_axis_tready = fwd && dout_axis_tready ? NUM_SOURCES'(1) << grant_id : '0;
  end
  // grant held for a whole packet or MAX_BURST beats, one idle cycle between grants
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= GW'(NUM_SOURCES - 1);
      beats <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_id <= pick;
          beats <= '0;
`ifdef UART_TX_ARB_TAG_EN
          state <= TAG;
`else
          state <= FORWARD;
`endif
        end
`ifdef UART_TX_ARB_TAG_EN
        TAG: if (dout_axis_tready) state <= FORWARD;
`endif
        FORWARD: if (sel_valid && dout_axis_tready) begin
          beats <= beats + 1'b1;
          if (sel_last || beats == CW'(MAX_BURST - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus against a per-cycle packet-level model of the arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*W-1:0] din_axis_tdata;
  logic [N-1:0] din_axis_tvalid, din_axis_tlast, din_axis_tready;
  logic [W-1:0] dout_axis_tdata;
  logic dout_axis_tvalid;
  logic dout_axis_tready;
  logic [1:0] grant_id;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NUM_SOURCES(N), .WORD_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .din_axis_tdata(din_axis_tdata),
    .din_axis_tvalid(din_axis_tvalid),
    .din_axis_tlast(din_axis_tlast),
    .din_axis_tready(din_axis_tready),
    .dout_axis_tdata(dout_axis_tdata),
    .dout_axis_tvalid(dout_axis_tvalid),
    .dout_axis_tready(dout_axis_tready),
    .grant_id(grant_id)
  );
  typedef struct {int g; int d; int c;} ev_t;
  logic [8:0] q[N][$];
  ev_t log_q[$];
  int tests = 0, fails = 0, cyc = 0;
  bit m_busy = 1'b0;
  int m_gid = N - 1, m_cnt = 0;
  bit rdy_toggle = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic ev_t lg(input int i);
    ev_t e;
    e = '{-1, -1, -1};
    if (i >= 0 && i < log_q.size()) e = log_q[i];
    return e;
  endfunction
  task automatic tick(input bit r);
    bit exp_v, found;
    logic [7:0] exp_d;
    logic [N-1:0] exp_r;
    int ng;
    @(negedge clk);
    rst = r;
    dout_axis_tready = rdy_toggle ? ~dout_axis_tready : 1'b1;
    for (int k = 0; k < N; k++) begin
      din_axis_tvalid[k] = q[k].size() > 0;
      din_axis_tdata[k*W +: W] = q[k].size() > 0 ? q[k][0][7:0] : 8'h00;
      din_axis_tlast[k] = q[k].size() > 0 ? q[k][0][8] : 1'b0;
    end
    #1;
    exp_v = m_busy && q[m_gid].size() > 0;
    exp_d = exp_v ? q[m_gid][0][7:0] : 8'h00;
    exp_r = (m_busy && dout_axis_tready) ? N'(1) << m_gid : '0;
    chk("tvalid", dout_axis_tvalid, exp_v);
    chk("tdata", dout_axis_tdata, exp_d);
    chk("din_tready", din_axis_tready, exp_r);
    chk("grant_id", grant_id, m_gid);
    if (dout_axis_tvalid && dout_axis_tready) log_q.push_back('{int'(grant_id), int'(dout_axis_tdata), cyc});
    if (r) begin
      m_busy = 1'b0;
      m_gid = N - 1;
      m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      ng = 0;
      for (int k = 1; k <= N; k++)
        if (!found && q[(m_gid + k) % N].size() > 0) begin
          ng = (m_gid + k) % N;
          found = 1'b1;
        end
      if (found) begin
        m_gid = ng;
        m_busy = 1'b1;
        m_cnt = 0;
      end
    end else if (exp_v && dout_axis_tready) begin
      m_cnt++;
      if (q[m_gid][0][8] || m_cnt == MB) m_busy = 1'b0;
    end
    for (int k = 0; k < N; k++)
      if (din_axis_tvalid[k] && din_axis_tready[k] && q[k].size() > 0) void'(q[k].pop_front());
    cyc++;
  endtask
  function automatic bit pending();
    bit p;
    p = m_busy;
    for (int k = 0; k < N; k++) if (q[k].size() > 0) p = 1'b1;
    return p;
  endfunction
  task automatic wait_done();
    int n;
    n = 0;
    while (pending() && n < 300) begin
      tick(1'b0);
      n++;
    end
    chk("drain_timeout", n >= 300, 0);
    tick(1'b0);
  endtask
  int base, lc, n;
  ev_t e;
  initial begin
    din_axis_tdata = '0;
    din_axis_tvalid = '0;
    din_axis_tlast = '0;
    dout_axis_tready = 1'b1;
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    chk("rst_grant", grant_id, 2'd3);
    chk("rst_tvalid", dout_axis_tvalid, 1'b0);
    chk("rst_tready", din_axis_tready, 4'h0);
    chk("rst_tdata", dout_axis_tdata, 8'h00);
    // single source 1, two-beat packet
    q[1].push_back({1'b0, 8'hA5});
    q[1].push_back({1'b1, 8'h5A});
    base = log_q.size();
    lc = cyc;
    wait_done();
    e = lg(base);
    chk("a_g0", e.g, 1); chk("a_d0", e.d, 8'hA5); chk("a_c0", e.c, lc + 1);
    e = lg(base + 1);
    chk("a_g1", e.g, 1); chk("a_d1", e.d, 8'h5A); chk("a_c1", e.c, lc + 2);
    chk("a_count", log_q.size() - base, 2);
    chk("a_grant_after", grant_id, 2'd1);
    // all four sources, one-beat packets, after reset
    tick(1'b1);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) q[k].push_back({1'b1, 8'(16 * k + r)});
    base = log_q.size();
    wait_done();
    chk("b_count", log_q.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      e = lg(base + i);
      chk($sformatf("b_g%0d", i), e.g, i % 4);
      chk($sformatf("b_d%0d", i), e.d, 16 * (i % 4) + i / 4);
      if (i > 0) chk($sformatf("b_gap%0d", i), e.c - lg(base + i - 1).c, 2);
    end
    // source 2 bursts past MAX_BURST while source 3 waits
    for (int i = 0; i < 20; i++) q[2].push_back({i == 19, 8'(8'h80 + i)});
    q[3].push_back({1'b1, 8'h33});
    base = log_q.size();
    wait_done();
    chk("c_count", log_q.size() - base, 21);
    for (int i = 0; i < 21; i++) begin
      e = lg(base + i);
      chk($sformatf("c_g%0d", i), e.g, i < 16 ? 2 : i == 16 ? 3 : 2);
      chk($sformatf("c_d%0d", i), e.d, i < 16 ? 8'h80 + i : i == 16 ? 8'h33 : 8'h80 + i - 1);
    end
    // backpressure toggling during a 4-beat packet
    rdy_toggle = 1'b1;
    for (int i = 0; i < 4; i++) q[0].push_back({i == 3, 8'(8'hC0 + i)});
    base = log_q.size();
    wait_done();
    rdy_toggle = 1'b0;
    chk("d_count", log_q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      e = lg(base + i);
      chk($sformatf("d_g%0d", i), e.g, 0);
      chk($sformatf("d_d%0d", i), e.d, 8'hC0 + i);
    end
    // reset in the middle of a 5-beat packet
    for (int i = 0; i < 5; i++) q[1].push_back({i == 4, 8'(8'hD0 + i)});
    base = log_q.size();
    n = 0;
    while (log_q.size() < base + 2 && n < 50) begin
      tick(1'b0);
      n++;
    end
    chk("e_reach2", log_q.size() - base, 2);
    q[0].push_back({1'b1, 8'hE0});
    tick(1'b1);
    base = log_q.size();
    tick(1'b0);
    chk("e_rst_tvalid", dout_axis_tvalid, 1'b0);
    chk("e_rst_tready", din_axis_tready, 4'h0);
    chk("e_rst_grant", grant_id, 2'd3);
    chk("e_rst_tdata", dout_axis_tdata, 8'h00);
    wait_done();
    e = lg(base);
    chk("e_first_g", e.g, 0);
    chk("e_first_d", e.d, 8'hE0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
